// File: rtl/addq_rr_sched.sv
// addq_rr_sched: round-robin scheduler sharing one combinational sign-magnitude
// adder among NREQ requesters. One transaction at a time: grant in IDLE,
// one adder cycle in EXEC, then hold the tagged result in RESP until accepted.
module addq_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  input  logic [W-1:0]      add_sum,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  input  logic              rsp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] owner_reg;
  logic [W-1:0]   add_x_reg;
  logic [W-1:0]   add_y_reg;
  logic           rsp_valid_reg;
  logic [IDW-1:0] rsp_id_reg;
  logic [W-1:0]   rsp_sum_reg;

  // Arbitration results for the current cycle
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand_idx;

  // Unpacked views of the flat operand buses
  logic [W-1:0] x_arr [NREQ];
  logic [W-1:0] y_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign x_arr[gi] = req_x[gi*W +: W];
      assign y_arr[gi] = req_y[gi*W +: W];
    end
  endgenerate

  // Round-robin search starting at ptr; walking offsets from the far end down
  // lets the closest requester (smallest offset) overwrite any later match.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NREQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NREQ);
      end
      cand_idx = cand_sum[IDW-1:0];
      if (req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // One-hot grant, only while idle and never during reset
  always_comb begin
    gnt = '0;
    if (!rst && (state_reg == IDLE) && win_found) begin
      gnt[win_idx] = 1'b1;
    end
  end

  // Scheduler FSM: capture operands at grant, sum after one adder cycle,
  // hold the response until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      owner_reg     <= '0;
      add_x_reg     <= '0;
      add_y_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_sum_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            add_x_reg <= x_arr[win_idx];
            add_y_reg <= y_arr[win_idx];
            owner_reg <= win_idx;
            ptr_reg   <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_reg   <= add_sum;
          rsp_id_reg    <= owner_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign add_x     = add_x_reg;
  assign add_y     = add_y_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_addq_rr_sched.sv
// Bench for addq_rr_sched: models the shared sign-magnitude adder, keeps a
// scoreboard of expected responses pushed at each grant, and runs one task
// per scenario.
module tb_addq_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      add_x;
  logic [W-1:0]      add_y;
  logic [W-1:0]      add_sum;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_ready;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [IDW+W-1:0] sb_q[$];

  addq_rr_sched #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .gnt       (gnt),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sign-magnitude adder model: magnitudes wrap, equal opposite operands give +0
  function automatic logic [W-1:0] sm_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-2:0] ma;
    logic [W-2:0] mb;
    ma = a[W-2:0];
    mb = b[W-2:0];
    if (a[W-1] == b[W-1]) return {a[W-1], ma + mb};
    if (ma == mb) return '0;
    if (ma > mb) return {a[W-1], ma - mb};
    return {b[W-1], mb - ma};
  endfunction

  assign add_sum = sm_add(add_x, add_y);

  // Scoreboard: push at every grant, pop and compare at every response handshake
  always @(negedge clk) begin
    int idx;
    bit hit;
    logic [IDW+W-1:0] exp_v;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (gnt != '0) begin
        checks++;
        if (!$onehot(gnt)) begin
          errors++;
          $display("FAIL gnt_onehot: got %b, required exactly one bit set", gnt);
        end
        idx = 0;
        hit = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i] && !hit) begin
            idx = i;
            hit = 1'b1;
          end
        end
        sb_q.push_back({IDW'(idx), sm_add(req_x[idx*W +: W], req_y[idx*W +: W])});
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_rsp: got id=%0d sum=%h, required no response", rsp_id, rsp_sum);
        end else begin
          exp_v = sb_q.pop_front();
          if ({rsp_id, rsp_sum} !== exp_v) begin
            errors++;
            $display("FAIL sb_rsp: got id=%0d sum=%h, required id=%0d sum=%h",
                     rsp_id, rsp_sum, exp_v[IDW+W-1:W], exp_v[W-1:0]);
          end else begin
            $display("rsp id=%0d sum=%h ok", rsp_id, rsp_sum);
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && busy; n++) cycle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'h1111 * (i + 1), 16'h0101);
    cycle();
    cycle();
    checks++;
    if ({gnt, busy, rsp_valid, rsp_id, rsp_sum, add_x, add_y} !== '0) begin
      errors++;
      $display("FAIL reset_state: got gnt=%b busy=%b rv=%b id=%0d sum=%h ax=%h ay=%h, required all 0",
               gnt, busy, rsp_valid, rsp_id, rsp_sum, add_x, add_y);
    end
    req = '0;
    rst = 1'b0;
    cycle();
    $display("reset checked");
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_ops(0, 16'h0003, 16'h0002);
    req = 4'b0001;
    #1;
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_gnt: got gnt=%b busy=%b, required 0001 busy=0", gnt, busy);
    end
    cycle();
    req = '0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b1 || add_x !== 16'h0003 || add_y !== 16'h0002) begin
      errors++;
      $display("FAIL t1_exec: got gnt=%b busy=%b ax=%h ay=%h, required 0000 1 0003 0002",
               gnt, busy, add_x, add_y);
    end
    cycle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'h0005) begin
      errors++;
      $display("FAIL t1_rsp: got rv=%b id=%0d sum=%h, required 1 0 0005", rsp_valid, rsp_id, rsp_sum);
    end
    cycle();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || add_x !== 16'h0003) begin
      errors++;
      $display("FAIL t1_idle: got rv=%b busy=%b ax=%h, required 0 0 0003", rsp_valid, busy, add_x);
    end
    $display("t1 single done");
  endtask

  task automatic test_back_to_back();
    int ord[5] = '{0, 1, 2, 3, 0};
    int n;
    reset_pulse();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'h0010 + 16'(i), 16'h8004 + 16'(i * 3));
    req = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      if (g > 0) begin
        do begin
          cycle();
          n++;
        end while (gnt == '0 && n < 20);
      end
      checks++;
      if (gnt !== (4'b0001 << ord[g]) || (g > 0 && n != 3)) begin
        errors++;
        $display("FAIL t2_order[%0d]: got gnt=%b interval=%0d, required gnt=%b interval=3",
                 g, gnt, n, 4'b0001 << ord[g]);
      end else begin
        $display("t2 grant %0d to req %0d", g, ord[g]);
      end
    end
    cycle();
    req = '0;
    drain();
  endtask

  task automatic test_neg_operand();
    rsp_ready = 1'b1;
    set_ops(2, 16'h8005, 16'h0003);
    req = 4'b0100;
    #1;
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL t3_gnt: got %b, required 0100", gnt);
    end
    cycle();
    req = '0;
    for (int n = 0; n < 10 && !rsp_valid; n++) cycle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 16'h8002) begin
      errors++;
      $display("FAIL t3_rsp: got rv=%b id=%0d sum=%h, required 1 2 8002", rsp_valid, rsp_id, rsp_sum);
    end
    drain();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_ops(0, 16'h0010, 16'h0020);
    set_ops(1, 16'h0100, 16'h8001);
    req = 4'b0001;
    #1;
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL t4_gnt0: got %b, required 0001", gnt);
    end
    cycle();
    req = 4'b0010;
    cycle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'h0030 || gnt !== 4'b0000 ||
          add_x !== 16'h0010 || add_y !== 16'h0020) begin
        errors++;
        $display("FAIL t4_hold[%0d]: got rv=%b id=%0d sum=%h gnt=%b ax=%h ay=%h, required 1 0 0030 0000 0010 0020",
                 i, rsp_valid, rsp_id, rsp_sum, gnt, add_x, add_y);
      end
      cycle();
    end
    rsp_ready = 1'b1;
    cycle();
    checks++;
    if (gnt !== 4'b0010 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL t4_after: got gnt=%b rv=%b, required 0010 0", gnt, rsp_valid);
    end
    cycle();
    req = '0;
    drain();
    $display("t4 backpressure done");
  endtask

  task automatic test_wrap();
    reset_pulse();
    rsp_ready = 1'b1;
    set_ops(2, 16'h0001, 16'h0001);
    req = 4'b0100;
    cycle();
    req = '0;
    drain();
    set_ops(3, 16'h7FFF, 16'h0002);
    set_ops(1, 16'h8003, 16'h0003);
    req = 4'b1010;
    #1;
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL t5_first: got %b, required 1000", gnt);
    end
    cycle();
    for (int n = 0; n < 10 && gnt == '0; n++) cycle();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL t5_wrap: got %b, required 0010", gnt);
    end
    cycle();
    req = '0;
    drain();
    $display("t5 wrap done");
  endtask

  task automatic test_rst_exec();
    rsp_ready = 1'b1;
    set_ops(1, 16'h0040, 16'h0004);
    set_ops(2, 16'h0002, 16'h0002);
    req = 4'b0010;
    #1;
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL t6_pre: got %b, required 0010", gnt);
    end
    cycle();
    req = 4'b0110;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL t6_in_rst: got rv=%b busy=%b gnt=%b, required 0 0 0000", rsp_valid, busy, gnt);
    end
    cycle();
    rst = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0010 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL t6_after: got gnt=%b rv=%b, required 0010 0", gnt, rsp_valid);
    end
    cycle();
    req = '0;
    drain();
    $display("t6 reset-in-exec done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_neg_operand();
    test_backpressure();
    test_wrap();
    test_rst_exec();
    cycle();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
